// File: rtl/boolean_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module      : boolean_resp_checker
//  Description : Consumer-side response checker for F = (B & D) | (~B & ~D).
//                Accepts {ABCD, F} samples on a valid/ready handshake, compares
//                F against the golden value and keeps saturating sample/error
//                counters, a 16-entry coverage map, first-error capture and a
//                done/pass verdict.
//  Revision    : 1.0 - initial release
// ============================================================================
module boolean_resp_checker #(
   parameter int CNT_W       = 8,
   parameter bit STOP_ON_ERR = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [3:0]       s_abcd,
   input  logic             s_f,
   output logic             err_pulse,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [15:0]      cov_map,
   output logic             first_err_valid,
   output logic [3:0]       first_err_abcd,
   output logic             done,
   output logic             pass
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_cnt_max = '1;
   localparam logic [15:0]      c_cov_full = 16'hFFFF;

   state_t           r_state;

   logic             w_accept;
   logic             w_exp;
   logic             w_mismatch;
   logic [15:0]      w_cov_next;
   logic [CNT_W-1:0] w_sample_next;
   logic [CNT_W-1:0] w_err_next;
   logic             w_finish;

   // A start request always wins over sampling, so the handshake drops that cycle.
   assign s_ready = (r_state == RUN) && !start;

   // Next-value computation for one accepted sample.
   always_comb begin
      w_accept      = s_valid && s_ready;
      w_exp         = ~(s_abcd[2] ^ s_abcd[0]);
      w_mismatch    = w_accept && (s_f != w_exp);
      w_cov_next    = cov_map | (16'd1 << s_abcd);
      w_sample_next = (sample_cnt == c_cnt_max) ? sample_cnt : sample_cnt + 1'b1;
      w_err_next    = err_cnt;
      if (w_mismatch && (err_cnt != c_cnt_max)) begin
         w_err_next = err_cnt + 1'b1;
      end
      w_finish      = (w_cov_next == c_cov_full) || (STOP_ON_ERR && w_mismatch);
   end

   // State machine and registered statistics; stats only move on an accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= IDLE;
         err_pulse       <= 1'b0;
         sample_cnt      <= '0;
         err_cnt         <= '0;
         cov_map         <= '0;
         first_err_valid <= 1'b0;
         first_err_abcd  <= '0;
         done            <= 1'b0;
         pass            <= 1'b0;
      end else begin
         err_pulse <= 1'b0;
         if (start) begin
            r_state         <= RUN;
            sample_cnt      <= '0;
            err_cnt         <= '0;
            cov_map         <= '0;
            first_err_valid <= 1'b0;
            first_err_abcd  <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
         end else if (w_accept) begin
            sample_cnt <= w_sample_next;
            err_cnt    <= w_err_next;
            cov_map    <= w_cov_next;
            if (w_mismatch) begin
               err_pulse <= 1'b1;
               if (!first_err_valid) begin
                  first_err_valid <= 1'b1;
                  first_err_abcd  <= s_abcd;
               end
            end
            // The final sample's contribution is folded into the verdict.
            if (w_finish) begin
               r_state <= DONE;
               done    <= 1'b1;
               pass    <= (w_err_next == '0) && (w_cov_next == c_cov_full);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_boolean_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_boolean_resp_checker
//  Description : Bench for boolean_resp_checker. Three instances share the
//                stimulus: (8-bit, run-to-coverage), (4-bit, stop-on-error),
//                (4-bit, run-to-coverage). A behavioural model per instance
//                predicts every output from the checker's rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_boolean_resp_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       s_valid = 1'b0;
   logic [3:0] s_abcd = 4'd0;
   logic       s_f = 1'b0;

   logic       rdy [3];
   logic       a_pulse, b_pulse, c_pulse;
   logic [7:0] a_smp, a_err;
   logic [3:0] b_smp, b_err, c_smp, c_err;
   logic [15:0] a_cov, b_cov, c_cov;
   logic       a_fev, b_fev, c_fev;
   logic [3:0] a_fea, b_fea, c_fea;
   logic       a_done, b_done, c_done;
   logic       a_pass, b_pass, c_pass;
   logic [39:0] obs [3];

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   boolean_resp_checker #(.CNT_W(8), .STOP_ON_ERR(1'b0)) u_a (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(rdy[0]),
      .s_abcd(s_abcd), .s_f(s_f), .err_pulse(a_pulse), .sample_cnt(a_smp),
      .err_cnt(a_err), .cov_map(a_cov), .first_err_valid(a_fev),
      .first_err_abcd(a_fea), .done(a_done), .pass(a_pass));

   boolean_resp_checker #(.CNT_W(4), .STOP_ON_ERR(1'b1)) u_b (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(rdy[1]),
      .s_abcd(s_abcd), .s_f(s_f), .err_pulse(b_pulse), .sample_cnt(b_smp),
      .err_cnt(b_err), .cov_map(b_cov), .first_err_valid(b_fev),
      .first_err_abcd(b_fea), .done(b_done), .pass(b_pass));

   boolean_resp_checker #(.CNT_W(4), .STOP_ON_ERR(1'b0)) u_c (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(rdy[2]),
      .s_abcd(s_abcd), .s_f(s_f), .err_pulse(c_pulse), .sample_cnt(c_smp),
      .err_cnt(c_err), .cov_map(c_cov), .first_err_valid(c_fev),
      .first_err_abcd(c_fea), .done(c_done), .pass(c_pass));

   // Flattened view: {pulse, smp[7:0], err[7:0], cov, fev, fea, done, pass}
   assign obs[0] = {a_pulse, a_smp, a_err, a_cov, a_fev, a_fea, a_done, a_pass};
   assign obs[1] = {b_pulse, 4'd0, b_smp, 4'd0, b_err, b_cov, b_fev, b_fea, b_done, b_pass};
   assign obs[2] = {c_pulse, 4'd0, c_smp, 4'd0, c_err, c_cov, c_fev, c_fea, c_done, c_pass};

   // Behavioural model, one slot per instance. State: 0 idle, 1 running, 2 finished.
   int        cnt_max [3] = '{255, 15, 15};
   bit        stop_on [3] = '{1'b0, 1'b1, 1'b0};
   int        m_st    [3];
   int        m_smp   [3];
   int        m_err   [3];
   bit        m_seen  [3][16];
   bit        m_pulse [3];
   bit        m_fev   [3];
   int        m_fea   [3];
   bit        m_done  [3];
   bit        m_pass  [3];
   logic      pre_rdy [3];
   bit        exp_rdy [3];

   function automatic bit golden(input int v);
      int b, d;
      b = (v >> 2) & 1;
      d = v & 1;
      return ((b & d) | ((1 - b) & (1 - d))) != 0;
   endfunction

   function automatic bit all_seen(input int k);
      for (int i = 0; i < 16; i++) if (!m_seen[k][i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [39:0] exp_vec(input int k);
      logic [15:0] cov;
      logic [7:0]  s8, e8;
      logic [3:0]  f4;
      for (int i = 0; i < 16; i++) cov[i] = m_seen[k][i];
      s8 = m_smp[k][7:0];
      e8 = m_err[k][7:0];
      f4 = m_fea[k][3:0];
      return {m_pulse[k], s8, e8, cov, m_fev[k], f4, m_done[k], m_pass[k]};
   endfunction

   // One clock: apply inputs, snapshot ready, clock, advance the model.
   task automatic tick(input bit r, input bit st, input bit v, input int abcd, input bit f);
      bit bad;
      rst = r; start = st; s_valid = v; s_abcd = abcd[3:0]; s_f = f;
      #1;
      for (int k = 0; k < 3; k++) begin
         pre_rdy[k] = rdy[k];
         exp_rdy[k] = (m_st[k] == 1) && !st;
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         if (r) begin
            m_st[k] = 0; m_smp[k] = 0; m_err[k] = 0; m_pulse[k] = 0;
            m_fev[k] = 0; m_fea[k] = 0; m_done[k] = 0; m_pass[k] = 0;
            for (int i = 0; i < 16; i++) m_seen[k][i] = 0;
         end else begin
            m_pulse[k] = 0;
            if (st) begin
               m_st[k] = 1; m_smp[k] = 0; m_err[k] = 0; m_fev[k] = 0;
               m_fea[k] = 0; m_done[k] = 0; m_pass[k] = 0;
               for (int i = 0; i < 16; i++) m_seen[k][i] = 0;
            end else if (m_st[k] == 1 && v) begin
               bad = (f != golden(abcd));
               m_smp[k] = (m_smp[k] < cnt_max[k]) ? m_smp[k] + 1 : cnt_max[k];
               m_seen[k][abcd] = 1;
               if (bad) begin
                  m_err[k] = (m_err[k] < cnt_max[k]) ? m_err[k] + 1 : cnt_max[k];
                  m_pulse[k] = 1;
                  if (!m_fev[k]) begin m_fev[k] = 1; m_fea[k] = abcd; end
               end
               if (all_seen(k) || (stop_on[k] && bad)) begin
                  m_st[k] = 2; m_done[k] = 1;
                  m_pass[k] = (m_err[k] == 0) && all_seen(k);
               end
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      tick(1, 1, 1, 10, 0);
      tick(1, 0, 1, 10, 0);
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (obs[k] !== 40'h0) begin
            n_fail++; $display("FAIL reset_outputs dut%0d: got %h expected 0", k, obs[k]);
         end
      end
      // valid in IDLE is ignored
      tick(0, 0, 1, 3, 1);
      tick(0, 0, 1, 7, 1);
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (pre_rdy[k] !== 1'b0 || obs[k] !== 40'h0) begin
            n_fail++; $display("FAIL idle_ignore dut%0d: ready %b stats %h expected ready 0 stats 0", k, pre_rdy[k], obs[k]);
         end
      end
   endtask

   task automatic test_all_pass();
      tick(0, 1, 0, 0, 0);
      for (int v = 0; v < 16; v++) begin
         tick(0, 0, 1, v, golden(v));
         n_cmp++;
         if (a_done !== (v == 15)) begin
            n_fail++; $display("FAIL all_pass_done v%0d: got %b expected %b", v, a_done, (v == 15));
         end
      end
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (obs[k] !== exp_vec(k)) begin
            n_fail++; $display("FAIL all_pass dut%0d: got %h expected %h", k, obs[k], exp_vec(k));
         end
      end
      n_cmp++;
      if (a_smp !== 8'd16 || a_cov !== 16'hFFFF || a_pass !== 1'b1 || a_err !== 8'd0) begin
         n_fail++; $display("FAIL all_pass_final: smp %0d cov %h pass %b err %0d expected 16 FFFF 1 0", a_smp, a_cov, a_pass, a_err);
      end
   endtask

   task automatic test_mismatch();
      tick(0, 1, 0, 0, 0);
      for (int v = 0; v < 16; v++) begin
         tick(0, 0, 1, v, (v == 5) ? 1'b0 : golden(v));
         n_cmp++;
         if (a_pulse !== (v == 5)) begin
            n_fail++; $display("FAIL mismatch_pulse v%0d: got %b expected %b", v, a_pulse, (v == 5));
         end
         if (v == 5) begin
            n_cmp++;
            if (b_done !== 1'b1 || b_smp !== 4'd6 || b_pass !== 1'b0) begin
               n_fail++; $display("FAIL stop_on_err: done %b smp %0d pass %b expected 1 6 0", b_done, b_smp, b_pass);
            end
         end
      end
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (obs[k] !== exp_vec(k)) begin
            n_fail++; $display("FAIL mismatch dut%0d: got %h expected %h", k, obs[k], exp_vec(k));
         end
      end
      n_cmp++;
      if (a_err !== 8'd1 || a_fea !== 4'd5 || a_fev !== 1'b1 || a_done !== 1'b1 || a_pass !== 1'b0) begin
         n_fail++; $display("FAIL mismatch_final: err %0d fea %0d fev %b done %b pass %b expected 1 5 1 1 0", a_err, a_fea, a_fev, a_done, a_pass);
      end
   endtask

   task automatic test_duplicate();
      tick(0, 1, 0, 0, 0);
      tick(0, 0, 1, 0, golden(0));
      for (int v = 0; v < 16; v++) begin
         tick(0, 0, 1, v, golden(v));
         n_cmp++;
         if (a_done !== (v == 15)) begin
            n_fail++; $display("FAIL dup_done v%0d: got %b expected %b", v, a_done, (v == 15));
         end
      end
      n_cmp++;
      if (a_smp !== 8'd17 || a_cov !== 16'hFFFF || a_pass !== 1'b1) begin
         n_fail++; $display("FAIL dup_final: smp %0d cov %h pass %b expected 17 FFFF 1", a_smp, a_cov, a_pass);
      end
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (obs[k] !== exp_vec(k)) begin
            n_fail++; $display("FAIL duplicate dut%0d: got %h expected %h", k, obs[k], exp_vec(k));
         end
      end
   endtask

   task automatic test_done_ignore();
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, 1, i + 2, 1'b0);
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (pre_rdy[k] !== 1'b0 || obs[k] !== exp_vec(k)) begin
               n_fail++; $display("FAIL done_ignore dut%0d: ready %b stats %h expected ready 0 stats %h", k, pre_rdy[k], obs[k], exp_vec(k));
            end
         end
      end
   endtask

   task automatic test_saturate();
      tick(0, 1, 0, 0, 0);
      for (int i = 0; i < 20; i++) tick(0, 0, 1, 0, 1'b0);
      tick(0, 0, 0, 0, 0);
      n_cmp++;
      if (c_smp !== 4'd15 || c_err !== 4'd15 || c_fea !== 4'd0 || c_fev !== 1'b1 || pre_rdy[2] !== 1'b1 || c_done !== 1'b0) begin
         n_fail++; $display("FAIL saturate4: smp %0d err %0d fea %0d fev %b ready %b done %b expected 15 15 0 1 1 0", c_smp, c_err, c_fea, c_fev, pre_rdy[2], c_done);
      end
      n_cmp++;
      if (a_smp !== 8'd20 || a_err !== 8'd20) begin
         n_fail++; $display("FAIL saturate8: smp %0d err %0d expected 20 20", a_smp, a_err);
      end
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (obs[k] !== exp_vec(k)) begin
            n_fail++; $display("FAIL saturate dut%0d: got %h expected %h", k, obs[k], exp_vec(k));
         end
      end
   endtask

   task automatic test_restart();
      tick(0, 1, 0, 0, 0);
      for (int v = 0; v < 8; v++) tick(0, 0, 1, v, golden(v));
      tick(0, 1, 1, 8, golden(8));
      n_cmp++;
      if (pre_rdy[0] !== 1'b0 || a_smp !== 8'd0 || a_cov !== 16'h0 || a_done !== 1'b0) begin
         n_fail++; $display("FAIL restart_clear: ready %b smp %0d cov %h done %b expected 0 0 0 0", pre_rdy[0], a_smp, a_cov, a_done);
      end
      tick(0, 0, 1, 9, golden(9));
      n_cmp++;
      if (pre_rdy[0] !== 1'b1 || a_smp !== 8'd1 || a_cov !== 16'h0200) begin
         n_fail++; $display("FAIL restart_run: ready %b smp %0d cov %h expected 1 1 0200", pre_rdy[0], a_smp, a_cov);
      end
      for (int v = 0; v < 7; v++) tick(0, 0, 1, v, golden(v));
      tick(1, 1, 1, 3, 0);
      tick(0, 0, 1, 4, golden(4));
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (pre_rdy[k] !== 1'b0 || obs[k] !== 40'h0) begin
            n_fail++; $display("FAIL restart_rst dut%0d: ready %b stats %h expected 0 0", k, pre_rdy[k], obs[k]);
         end
      end
   endtask

   task automatic test_random();
      bit r, st, v, f;
      int abcd;
      for (int i = 0; i < 600; i++) begin
         r    = ($urandom_range(0, 99) == 0);
         st   = ($urandom_range(0, 39) == 0);
         v    = ($urandom_range(0, 3) != 0);
         abcd = $urandom_range(0, 15);
         f    = ($urandom_range(0, 15) == 0) ? !golden(abcd) : golden(abcd);
         tick(r, st, v, abcd, f);
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (obs[k] !== exp_vec(k) || (!r && pre_rdy[k] !== exp_rdy[k])) begin
               n_fail++; $display("FAIL random c%0d dut%0d: stats %h ready %b expected %h %b", i, k, obs[k], pre_rdy[k], exp_vec(k), exp_rdy[k]);
            end
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         m_st[k] = 0; m_smp[k] = 0; m_err[k] = 0; m_pulse[k] = 0;
         m_fev[k] = 0; m_fea[k] = 0; m_done[k] = 0; m_pass[k] = 0;
         for (int i = 0; i < 16; i++) m_seen[k][i] = 0;
      end
      @(posedge clk);
      #1;
      test_reset();
      test_all_pass();
      test_mismatch();
      test_duplicate();
      test_done_ignore();
      test_saturate();
      test_restart();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
